main_fsm: RTL
=============

MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; `clk` and `reset` SHALL be listed before all other ports.
REQ-002 The ports SHALL be, one per entry (name  direction  width  meaning):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `Op`  in  2  instruction class: 00 data-processing, 01 memory, 10 branch, 11 illegal.
- `Funct`  in  6  instruction funct field: bit5 = I (immediate), bit0 = L (load).
- `IRWrite`  out  1  instruction-register load enable.
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALU result.
- `ALUSrcA`  out  1  ALU A operand select: 0 = register A, 1 = PC.
- `ALUSrcB`  out  2  ALU B operand select: 00 = register, 01 = ExtImm, 10 = constant 4.
- `ResultSrc`  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUOp`  out  1  ALU decoder uses Funct when 1, otherwise ADD.
- `NextPC`  out  1  PC update request, fed to condition logic.
- `RegW`  out  1  register write request, gated downstream by the condition.
- `MemW`  out  1  memory write request, gated downstream by the condition.
- `Branch`  out  1  branch request.
- `Retire`  out  1  final cycle of an instruction.
- `InstrCount`  out  32  retired-instruction count.
- `StateOut`  out  4  current state encoding, for debug.

Function
REQ-003 The FSM SHALL be Moore: every control output SHALL depend only on the current state; any output not listed for a state SHALL be 0.
REQ-004 State encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10; codes 11-15 SHALL go to FETCH on the next edge.
REQ-005 Transitions SHALL be:
- FETCH->DECODE.
- DECODE->MEMADR if Op=01.
- DECODE->EXECUTEI if Op=00 and Funct[5]=1.
- DECODE->EXECUTER if Op=00 and Funct[5]=0.
- DECODE->BRANCH if Op=10.
- DECODE->UNKNOWN if Op=11.
- MEMADR->MEMRD if Funct[0]=1, else MEMWR.
- MEMRD->MEMWB.
- EXECUTER/EXECUTEI->ALUWB.
- MEMWB, MEMWR, ALUWB, BRANCH, UNKNOWN->FETCH.
REQ-006 Op and Funct SHALL be sampled only in DECODE and MEMADR and ignored in all other states.
REQ-007 FETCH SHALL drive IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, NextPC=1.
REQ-008 DECODE SHALL drive ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
REQ-009 MEMADR SHALL drive ALUSrcA=0, ALUSrcB=01.
REQ-010 MEMRD SHALL drive AdrSrc=1.
REQ-011 MEMWB SHALL drive ResultSrc=01, RegW=1.
REQ-012 MEMWR SHALL drive AdrSrc=1, MemW=1.
REQ-013 EXECUTER SHALL drive ALUSrcA=0, ALUSrcB=00, ALUOp=1.
REQ-014 EXECUTEI SHALL drive ALUSrcA=0, ALUSrcB=01, ALUOp=1.
REQ-015 ALUWB SHALL drive ResultSrc=00, RegW=1.
REQ-016 BRANCH SHALL drive ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1.
REQ-017 UNKNOWN SHALL drive all control outputs 0.
REQ-018 Retire SHALL be 1 exactly in MEMWB, MEMWR, ALUWB, BRANCH and UNKNOWN.
REQ-019 InstrCount SHALL increment by 1 on each clock edge at which Retire=1, and SHALL wrap from 0xFFFFFFFF to 0 without a flag.
REQ-020 Instruction latencies SHALL be: load 5 cycles, store 4, data-processing 4, branch 3, illegal 3.
REQ-021 StateOut SHALL equal the state register value.

Reset
REQ-022 While reset=1 at a clock edge, the next state SHALL be FETCH and InstrCount SHALL be 0; reset SHALL take priority over any transition or increment.
REQ-023 After reset, outputs SHALL equal the FETCH values: IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, all others 0, Retire=0, StateOut=0.
REQ-024 A reset asserted in any state, including mid-instruction such as MEMRD, SHALL abort the instruction without a Retire count.

Structure
REQ-025 A shared package SHALL hold the state-code constants, the Op class constants (DP=00, MEM=01, BR=10) and the ALUSrcB/ResultSrc select constants, for use by the decoder and datapath.
REQ-026 The state register SHALL be the existing resettable flop (`flopr`, WIDTH=4, reset value 0 = FETCH); no new sub-module SHALL be created, and next-state logic, output decode and the counter SHALL be coded inline.

Verification
REQ-027 Reset held for 2 cycles then released with Op=01, Funct=000001 (LDR) -> states 0,1,2,3,4,0; RegW=1 only in MEMWB; InstrCount goes 0->1.
REQ-028 Op=01, Funct=000000 (STR) -> states 0,1,2,5,0; MemW=1 for exactly 1 cycle with AdrSrc=1.
REQ-029 Op=00 with Funct[5]=0, then with Funct[5]=1 -> EXECUTER (ALUSrcB=00) then EXECUTEI (ALUSrcB=01), each followed by ALUWB; InstrCount=2.
REQ-030 Op=10 -> BRANCH with Branch=1; Op=11 -> UNKNOWN with all controls 0; both return to FETCH; Retire=1 once each.
REQ-031 Reset asserted in MEMRD -> next state FETCH, InstrCount=0, no MemW or RegW pulse.
REQ-032 InstrCount preloaded via force to 0xFFFFFFFF, then one ALU instruction -> InstrCount=0x00000000.

Source files
------------

// File: rtl/main_fsm_pkg.sv
// Shared encodings for the multicycle control FSM: state codes, Op classes,
// operand/result select values and the control-word layout.
package main_fsm_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned CNT_W   = 32;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_EXT  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // Moore control word decoded from the current state.
    typedef struct packed {
        logic       ir_write;
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       alu_op;
        logic       next_pc;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       retire;
    } ctrl_t;

endpackage

// File: rtl/flopr.sv
// Resettable register with synchronous active-high reset to zero.
module flopr #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else       q <= d;
    end

endmodule

// File: rtl/main_fsm.sv
// Multicycle processor main controller: Moore FSM driving datapath selects,
// plus a free-running retired-instruction counter.
module main_fsm
    import main_fsm_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   Op,
    input  logic [5:0]   Funct,
    output logic         IRWrite,
    output logic         AdrSrc,
    output logic         ALUSrcA,
    output logic [1:0]   ALUSrcB,
    output logic [1:0]   ResultSrc,
    output logic         ALUOp,
    output logic         NextPC,
    output logic         RegW,
    output logic         MemW,
    output logic         Branch,
    output logic         Retire,
    output logic [31:0]  InstrCount,
    output logic [3:0]   StateOut
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    ctrl_t              ctrl;
    logic               unused_funct;

    assign unused_funct = ^Funct[4:1];

    flopr #(.WIDTH(STATE_W)) u_state_reg (
        .clk   (clk),
        .reset (reset),
        .d     (state_d),
        .q     (state_q)
    );

    // Next state and Moore outputs; Op/Funct only consulted in DECODE and MEMADR.
    always_comb begin
        state_d = S_FETCH;
        ctrl    = '0;
        case (state_q)
            S_FETCH: begin
                state_d         = S_DECODE;
                ctrl.ir_write   = 1'b1;
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALURES;
                ctrl.next_pc    = 1'b1;
            end
            S_DECODE: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALURES;
                case (Op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_UNKNOWN;
                endcase
            end
            S_MEMADR: begin
                state_d        = Funct[0] ? S_MEMRD : S_MEMWR;
                ctrl.alu_src_b = SRCB_EXT;
            end
            S_MEMRD: begin
                state_d      = S_MEMWB;
                ctrl.adr_src = 1'b1;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_w      = 1'b1;
                ctrl.retire     = 1'b1;
            end
            S_MEMWR: begin
                ctrl.adr_src = 1'b1;
                ctrl.mem_w   = 1'b1;
                ctrl.retire  = 1'b1;
            end
            S_EXECUTER: begin
                state_d        = S_ALUWB;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = 1'b1;
            end
            S_EXECUTEI: begin
                state_d        = S_ALUWB;
                ctrl.alu_src_b = SRCB_EXT;
                ctrl.alu_op    = 1'b1;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_w      = 1'b1;
                ctrl.retire     = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_b  = SRCB_EXT;
                ctrl.result_src = RES_ALURES;
                ctrl.branch     = 1'b1;
                ctrl.retire     = 1'b1;
            end
            S_UNKNOWN: begin
                ctrl.retire = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        count_d = count_q + CNT_W'(ctrl.retire);
    end

    // Retired-instruction counter; wraps silently.
    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign IRWrite    = ctrl.ir_write;
    assign AdrSrc     = ctrl.adr_src;
    assign ALUSrcA    = ctrl.alu_src_a;
    assign ALUSrcB    = ctrl.alu_src_b;
    assign ResultSrc  = ctrl.result_src;
    assign ALUOp      = ctrl.alu_op;
    assign NextPC     = ctrl.next_pc;
    assign RegW       = ctrl.reg_w;
    assign MemW       = ctrl.mem_w;
    assign Branch     = ctrl.branch;
    assign Retire     = ctrl.retire;
    assign InstrCount = count_q;
    assign StateOut   = state_q;

endmodule
